// File: rtl/main_mem_responder.sv
// ---------------------------------------------------------------------------
// main_mem_responder
//
// Memory-side responder for the data cache refill / write-through interface.
// One request is accepted at a time. A line read waits LATENCY cycles and
// then gathers BLOCK_WORDS words, one per cycle, into rsp_rdata before
// pulsing rsp_valid. A word write waits LATENCY cycles, commits the word and
// pulses rsp_valid. A side port (init_*) preloads the backing array.
//
// Ports
//   clk, rst        clock (rising edge) and synchronous active-high reset
//   req_valid/ready request handshake; ready is high only while idle
//   req_we          1 = single word write, 0 = full line read
//   req_addr        word address (taken modulo MEM_DEPTH)
//   req_wdata       write data for word writes
//   rsp_valid       one-cycle completion pulse
//   rsp_rdata       assembled line, word i at [i*MEM_WIDTH +: MEM_WIDTH]
//   busy            high whenever a transaction is in progress
//   init_we/addr/wdata  preload write port, usable in any state
// ---------------------------------------------------------------------------
module main_mem_responder #(
   parameter int MEM_WIDTH   = 32,
   parameter int MEM_DEPTH   = 1024,
   parameter int BLOCK_WORDS = 4,
   parameter int LATENCY     = 4,
   localparam int ADDR_W     = $clog2(MEM_DEPTH)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             req_valid,
   output logic                             req_ready,
   input  logic                             req_we,
   input  logic [ADDR_W-1:0]                req_addr,
   input  logic [MEM_WIDTH-1:0]             req_wdata,
   output logic                             rsp_valid,
   output logic [BLOCK_WORDS*MEM_WIDTH-1:0] rsp_rdata,
   output logic                             busy,
   input  logic                             init_we,
   input  logic [ADDR_W-1:0]                init_addr,
   input  logic [MEM_WIDTH-1:0]             init_wdata
);

   localparam int BEAT_W = $clog2(BLOCK_WORDS);
   localparam int CNT_W  = $clog2(LATENCY) + 1;
   localparam int LINE_W = BLOCK_WORDS * MEM_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_XFER,
      S_RESP
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [BEAT_W-1:0]     beat_q, beat_d;
   logic                  we_q, we_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [MEM_WIDTH-1:0]  wdata_q, wdata_d;
   logic [LINE_W-1:0]     rsp_rdata_q, rsp_rdata_d;

   // Backing store; deliberately never reset so contents survive rst.
   logic [MEM_WIDTH-1:0]  mem [MEM_DEPTH];

   logic                  commit;
   logic                  xfer_last;
   logic [ADDR_W-1:0]     xfer_addr;
   logic [MEM_WIDTH-1:0]  xfer_word;

   // A write commits on the edge that ends the final WAIT cycle.
   assign commit    = (state_q == S_WAIT) && (cnt_q == '0) && we_q;
   assign xfer_last = (state_q == S_XFER) && (beat_q == BEAT_W'(BLOCK_WORDS - 1));

   // Line base is the latched address with the in-line offset replaced by
   // the beat number, so the burst always stays inside one aligned line.
   assign xfer_addr = {addr_q[ADDR_W-1:BEAT_W], beat_q};
   assign xfer_word = mem[xfer_addr];

   // ------------------------------------------------------------------
   // Next-state / datapath logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      beat_d  = beat_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               state_d = S_WAIT;
               cnt_d   = CNT_W'(LATENCY - 1);
               we_d    = req_we;
               addr_d  = req_addr;
               wdata_d = req_wdata;
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               state_d = we_q ? S_RESP : S_XFER;
               beat_d  = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_XFER: begin
            if (xfer_last) begin
               state_d = S_RESP;
            end else begin
               beat_d = beat_q + BEAT_W'(1);
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Line assembly: only the word selected by the current beat is replaced,
   // everything else holds, so the last line survives writes and idle time.
   always_comb begin
      rsp_rdata_d = rsp_rdata_q;
      if (state_q == S_XFER) begin
         for (int i = 0; i < BLOCK_WORDS; i++) begin
            if (beat_q == BEAT_W'(i)) begin
               rsp_rdata_d[i*MEM_WIDTH +: MEM_WIDTH] = xfer_word;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         beat_q      <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         beat_q      <= beat_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // ------------------------------------------------------------------
   // Backing array writes. The request write is placed second so that it
   // wins over a preload to the same word on the same edge. A reset on the
   // commit edge discards the pending write.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (init_we) begin
         mem[init_addr] <= init_wdata;
      end
      if (commit && !rst) begin
         mem[addr_q] <= wdata_q;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign req_ready = (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_RESP);
   assign busy      = (state_q != S_IDLE);
   assign rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/main_mem_responder.md
Name: main_mem_responder

Overview:
Memory-side responder for the data cache's refill/write-through interface. It accepts one request at a time from the cache controller. A read returns a full cache line after a fixed access latency plus a one-word-per-cycle burst. A write commits a single word after the access latency. It owns the backing word array and provides a side port used by the bench/boot loader to preload contents.

Parameters:
MEM_WIDTH, 32, data word width in bits
MEM_DEPTH, 1024, number of words in the backing array (power of 2)
BLOCK_WORDS, 4, words per cache line (power of 2, ≥2); line = BLOCK_WORDS*MEM_WIDTH bits (128 by default)
LATENCY, 4, access latency in cycles before the transfer/commit (≥1)
ADDR_W, $clog2(MEM_DEPTH), word-address width (derived, not overridden)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset: synchronous and active-high
req_valid  in  1  cache presents a request
req_ready  out  1  responder can accept (high only in IDLE)
req_we  in  1  1 = word write, 0 = line read
req_addr  in  ADDR_W  word address
req_wdata  in  MEM_WIDTH  write data
rsp_valid  out  1  one-cycle completion pulse (read data valid / write acknowledged)
rsp_rdata  out  BLOCK_WORDS*MEM_WIDTH  assembled line; word i at bits [i*MEM_WIDTH +: MEM_WIDTH]
busy  out  1  high in any state other than IDLE
init_we  in  1  preload write strobe
init_addr  in  ADDR_W  preload word address
init_wdata  in  MEM_WIDTH  preload data

Behaviour:
- Reset (rst=1 at an edge): state→IDLE; req_ready=1, rsp_valid=0, busy=0, rsp_rdata=0; counters cleared. The memory array is NOT cleared.
- Accept: handshake at an edge with req_valid&&req_ready. Latch req_we, req_addr and req_wdata there. req_valid while busy is ignored; nothing is queued.
- States: IDLE→WAIT on accept.
- WAIT: lasts exactly LATENCY cycles (down-counter loaded with LATENCY-1). At its last cycle:
  - read→XFER
  - write→mem[addr] <= latched wdata, →RESP
- XFER (read only): BLOCK_WORDS cycles. Base = latched addr with low $clog2(BLOCK_WORDS) bits forced to 0. Cycle i captures mem[base+i] into rsp_rdata word i. After the last word →RESP.
- RESP: rsp_valid=1 for exactly one cycle, then →IDLE. req_ready becomes 1 in the following cycle, so back-to-back requests lose one idle cycle.
- Timing, counted from the accept edge as edge 0: read rsp_valid is high in cycle LATENCY+BLOCK_WORDS+1 (9 with defaults); write rsp_valid is high in cycle LATENCY+1 (5). The write is visible to any later read.
- rsp_rdata changes only during XFER. It holds the last line through write transactions and idle. During XFER it is partially updated and is valid only while rsp_valid=1 after a read.
- Addresses are taken modulo MEM_DEPTH. A line never crosses the array end because MEM_DEPTH is a multiple of BLOCK_WORDS.
- init_we: writes mem[init_addr] at the edge in any state. If it targets the same address as a request write committing at that same edge, the request write wins. An init write to a word not yet captured by XFER is seen by that XFER.
- Reset mid-transaction aborts immediately. A pending write that has not yet committed is discarded. rsp_valid is not issued.
- No X on outputs after the first reset edge.

Test Plan:
- Reset then preload mem[0..7]=0x1000_0000+i via init port. Read req_addr=5 → rsp_valid 9 cycles after accept; rsp_rdata=0x10000007_10000006_10000005_10000004; req_ready low during cycles 1–9.
- Write req_addr=2, wdata=0xDEADBEEF → rsp_valid at cycle 5. Then read addr 0 → word 2 =0xDEADBEEF, words 0,1,3 unchanged; rsp_rdata unchanged during the write transaction.
- Hold req_valid high with differing addresses across a whole transaction → exactly one accept; the second request is accepted only on the cycle after rsp_valid.
- Assert rst at cycle 3 of a write to addr 9 (old 0x55) → outputs return to reset values next cycle; mem[9] stays 0x55; no rsp_valid.
- Read addr 1020 with MEM_DEPTH=1024 → words 1020–1023 returned. Read addr 1024+4 (truncated to 4) → words 4–7 returned.
- At a write's commit edge to addr 3 (0xAAAA), also pulse init_we to addr 3 with 0xBBBB → mem[3]=0xAAAA. Init to addr 7 during XFER word 0 of a read from base 4 → rsp_rdata word 3 = new data.
